// File: rtl/timer_arb_pkg.sv
// Shared encodings for the timer request arbiter: FSM states and the serial frame layout.
package timer_arb_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] ACK       = 2'd3;

  localparam int unsigned FRAME_W       = 8;
  localparam int unsigned DELAY_W       = 4;
  localparam logic [3:0]  START_PATTERN = 4'b1101;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Scan downwards so the lowest offset from ptr wins.
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % int'(N_REQ)]) begin
        valid = 1'b1;
        idx   = ID_W'((int'(ptr) + i) % int'(N_REQ));
      end
    end
  end

endmodule

// File: rtl/timer_req_arbiter.sv
// Round-robin front end that serialises one client's delay frame onto a shared timer.
// Optional WAIT_DONE timeout is enabled by defining TIMER_ARB_TIMEOUT_EN.
module timer_req_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [DELAY_W*N_REQ-1:0] req_delay,
  output logic                     tmr_data,
  output logic                     tmr_ack,
  input  logic                     tmr_counting,
  input  logic                     tmr_done,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     cmp_valid,
  output logic [ID_W-1:0]          cmp_id,
  output logic                     err
);

  logic [1:0]         state_d, state_q;
  logic [ID_W-1:0]    ptr_d, ptr_q;
  logic [ID_W-1:0]    grant_id_d, grant_id_q;
  logic [FRAME_W-1:0] frame_d, frame_q;
  logic [2:0]         bit_cnt_d, bit_cnt_q;
  logic               tmr_data_d, tmr_data_q;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic [DELAY_W-1:0] pick_delay;
  logic [ID_W-1:0]    ptr_nxt;
  logic               timeout;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_id)
  );

  assign pick_delay = req_delay[pick_id*DELAY_W +: DELAY_W];
  assign ptr_nxt    = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef TIMER_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);

  logic [CntW-1:0] wait_cnt_d, wait_cnt_q;
  logic            seen_d, seen_q;
  logic            err_q;

  // A timer that never showed counting nor done is presumed dead.
  assign timeout = (state_q == WAIT_DONE) && !tmr_done && !tmr_counting && !seen_q &&
                   (wait_cnt_q == CntW'(WAIT_LIMIT - 1));

  always_comb begin
    wait_cnt_d = '0;
    seen_d     = 1'b0;
    if (state_q == WAIT_DONE) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      seen_d     = seen_q | tmr_counting;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      seen_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      seen_q     <= seen_d;
      err_q      <= timeout;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = tmr_counting | (WAIT_LIMIT == 0);
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    tmr_data_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          frame_d    = {START_PATTERN, pick_delay};
          // First frame bit goes out on the cycle right after the grant.
          tmr_data_d = START_PATTERN[3];
          bit_cnt_d  = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        frame_d   = frame_q << 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = WAIT_DONE;
        end else begin
          tmr_data_d = frame_q[FRAME_W-2];
        end
      end
      WAIT_DONE: begin
        if (tmr_done) begin
          state_d = ACK;
        end else if (timeout) begin
          ptr_d   = ptr_nxt;
          state_d = IDLE;
        end
      end
      ACK: begin
        ptr_d   = ptr_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      tmr_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      tmr_data_q <= tmr_data_d;
    end
  end

  assign tmr_data  = tmr_data_q;
  assign tmr_ack   = (state_q == ACK);
  assign cmp_valid = (state_q == ACK);
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;
  assign cmp_id    = (cmp_valid || err) ? grant_id_q : '0;

endmodule

// File: tb/tb_timer_req_arbiter.sv
// Directed bench for timer_req_arbiter with a small behavioural model of the serial timer.
module tb_timer_req_arbiter;

  localparam int TMR_CYC = 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] req_delay;
  logic        tmr_data, tmr_ack, tmr_counting, tmr_done;
  logic        busy, cmp_valid, err;
  logic [1:0]  grant_id, cmp_id;

  logic        tmr_en;
  logic        tmr_rst_n;
  logic [7:0]  sh;
  int          tcnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timer_req_arbiter #(
    .N_REQ      (4),
    .ID_W       (2),
    .WAIT_LIMIT (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_delay    (req_delay),
    .tmr_data     (tmr_data),
    .tmr_ack      (tmr_ack),
    .tmr_counting (tmr_counting),
    .tmr_done     (tmr_done),
    .busy         (busy),
    .grant_id     (grant_id),
    .cmp_valid    (cmp_valid),
    .cmp_id       (cmp_id),
    .err          (err)
  );

  // Timer model: 1101 + 4 delay bits, counts (delay+1)*TMR_CYC, done held until ack.
  always @(posedge clk or negedge tmr_rst_n) begin
    if (!tmr_rst_n) begin
      sh           <= '0;
      tcnt         <= 0;
      tmr_counting <= 1'b0;
      tmr_done     <= 1'b0;
    end else begin
      sh <= {sh[6:0], tmr_data};
      if (tmr_done && tmr_ack) tmr_done <= 1'b0;
      if (tmr_counting) begin
        if (tcnt <= 1) begin
          tmr_counting <= 1'b0;
          tmr_done     <= 1'b1;
        end
        tcnt <= tcnt - 1;
      end else if (tmr_en && !tmr_done && sh[6:3] == 4'b1101) begin
        tcnt         <= (int'({sh[2:0], tmr_data}) + 1) * TMR_CYC;
        tmr_counting <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input int exp_id, input logic [7:0] exp_frame, input int chg_at,
                         input logic [15:0] new_delays, input logic [3:0] wait_drop,
                         input logic [3:0] done_drop);
    logic [7:0] got;
    logic       prev_done;
    bit         seen;
    int         n;
    @(negedge clk);
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_grant", 32'(busy), 32'd1);
    check("grant_id", 32'(grant_id), exp_id);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      got[7-k] = tmr_data;
      if (k == chg_at) req_delay = new_delays;
    end
    check("frame", 32'(got), 32'(exp_frame));
    @(negedge clk);
    check("wait_data", 32'(tmr_data), 32'd0);
    req       = req & ~wait_drop;
    n         = 0;
    prev_done = 1'b0;
    seen      = 1'b0;
    while (n < 20000) begin
      if (cmp_valid) begin
        seen = 1'b1;
        break;
      end
      prev_done = tmr_done;
      @(negedge clk);
      n++;
    end
    check("cmp_seen", 32'(seen), 32'd1);
    check("done_lat", 32'(prev_done), 32'd1);
    check("ack", 32'(tmr_ack), 32'd1);
    check("cmp_id", 32'(cmp_id), exp_id);
    req = req & ~done_drop;
    @(negedge clk);
    check("gap_busy", 32'(busy), 32'd0);
    check("cmp_pulse", 32'(cmp_valid), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    tmr_rst_n = 1'b0;
    tmr_en    = 1'b1;
    req       = '0;
    req_delay = '0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(tmr_data), 32'd0);
    check("rst_ack", 32'(tmr_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_cmp", 32'(cmp_valid), 32'd0);
    check("rst_cid", 32'(cmp_id), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n   = 1'b1;
    tmr_rst_n = 1'b1;
    @(negedge clk);

    // Single client, delay 0.
    req = 4'b0001;
    run_job(0, 8'b1101_0000, -1, 16'h0, 4'h0, 4'b0001);

    // Clients 1 and 3 together; 1 first, 3 after exactly one idle cycle.
    req_delay = 16'h1020;
    req       = 4'b1010;
    run_job(1, 8'b1101_0010, -1, 16'h0, 4'h0, 4'b0010);
    run_job(3, 8'b1101_0001, -1, 16'h0, 4'h0, 4'b1000);

    // All four held: order 0,1,2,3,0.
    req_delay = 16'h0000;
    req       = 4'b1111;
    run_job(0, 8'hD0, -1, 16'h0, 4'h0, 4'h0);
    run_job(1, 8'hD0, -1, 16'h0, 4'h0, 4'h0);
    run_job(2, 8'hD0, -1, 16'h0, 4'h0, 4'h0);
    run_job(3, 8'hD0, -1, 16'h0, 4'h0, 4'h0);
    run_job(0, 8'hD0, -1, 16'h0, 4'h0, 4'hF);

    // Delay changes mid-frame and req drops during WAIT_DONE.
    req_delay = 16'h0005;
    req       = 4'b0001;
    run_job(0, 8'b1101_0101, 2, 16'h0009, 4'b0001, 4'h0);

    // Reset in the middle of SEND bit 3.
    req_delay = 16'h0000;
    req       = 4'b0001;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("rst_mid_busy", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      check("bit3_data", 32'(tmr_data), 32'd1);
      reset_n   = 1'b0;
      tmr_rst_n = 1'b0;
      #1;
      check("mid_rst_data", 32'(tmr_data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ack", 32'(tmr_ack), 32'd0);
      check("mid_rst_gid", 32'(grant_id), 32'd0);
      req = '0;
      @(negedge clk);
      reset_n   = 1'b1;
      tmr_rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        check("post_rst_data", 32'(tmr_data), 32'd0);
        check("post_rst_cnt", 32'(tmr_counting), 32'd0);
      end
    end

`ifdef TIMER_ARB_TIMEOUT_EN
    // Dead timer: err after the limit, no completion, next client granted.
    tmr_en = 1'b0;
    req    = 4'b0011;
    begin
      int  n;
      bit  any_cmp;
      n = 0;
      @(negedge clk);
      while (!busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("to_grant", 32'(grant_id), 32'd0);
      repeat (7) @(negedge clk);
      n       = 0;
      any_cmp = 1'b0;
      while (!err && n < 100) begin
        @(negedge clk);
        n++;
        if (cmp_valid) any_cmp = 1'b1;
      end
      check("to_latency", n, 17);
      check("to_cmp_id", 32'(cmp_id), 32'd0);
      check("to_no_cmp", 32'(any_cmp | cmp_valid), 32'd0);
      req = 4'b0010;
      @(negedge clk);
      check("to_err_pulse", 32'(err), 32'd0);
      check("to_next_busy", 32'(busy), 32'd1);
      check("to_next_gid", 32'(grant_id), 32'd1);
      req = '0;
      n   = 0;
      while (busy && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("to_idle", 32'(busy), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
